// File: rtl/result_mux_pipe.sv
// Result-select mux feeding a two-entry registered output stage (main + skid)
// with valid/ready handshake, flush, and clamping of out-of-range selects.
module result_mux_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_clamp,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned NUM_SEL_CODES = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    if (NUM_IN < 2 || NUM_IN > 16 || NUM_SEL_CODES < NUM_IN) begin : g_bad_params
        $error("result_mux_pipe: need 2 <= NUM_IN <= 16 and 2**SEL_W >= NUM_IN");
    end

    // State encodes {skid valid, main valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;
    logic               m_clamp_q, m_clamp_d;
    logic [WIDTH-1:0]   s_data_q, s_data_d;
    logic               s_clamp_q, s_clamp_d;

    logic               sel_clamp_c;
    logic [SEL_W-1:0]   sel_idx_c;
    logic [WIDTH-1:0]   sel_data_c;
    logic               accept_c;
    logic               deq_c;

    // Source selection; out-of-range selects fall back to the last source.
    always_comb begin
        sel_clamp_c = (in_sel > LAST_SEL);
        sel_idx_c   = sel_clamp_c ? LAST_SEL : in_sel;
        sel_data_c  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel_idx_c == SEL_W'(i)) begin
                sel_data_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_data_q;
    assign out_clamp = m_clamp_q;

    assign accept_c = in_valid && in_ready;
    assign deq_c    = out_valid && out_ready;

    // Next-state: flush empties both entries but leaves the data registers alone.
    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_clamp_d = m_clamp_q;
        s_data_d  = s_data_q;
        s_clamp_d = s_clamp_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        m_data_d  = sel_data_c;
                        m_clamp_d = sel_clamp_c;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (deq_c && accept_c) begin
                        m_data_d  = sel_data_c;
                        m_clamp_d = sel_clamp_c;
                    end else if (deq_c) begin
                        state_d = EMPTY;
                    end else if (accept_c) begin
                        s_data_d  = sel_data_c;
                        s_clamp_d = sel_clamp_c;
                        state_d   = TWO;
                    end
                end
                TWO: begin
                    if (deq_c) begin
                        m_data_d  = s_data_q;
                        m_clamp_d = s_clamp_q;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            m_data_q  <= '0;
            m_clamp_q <= 1'b0;
            s_data_q  <= '0;
            s_clamp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_clamp_q <= m_clamp_d;
            s_data_q  <= s_data_d;
            s_clamp_q <= s_clamp_d;
        end
    end

    a_legal_state: assert property (@(posedge clk) disable iff (reset)
        state_q inside {EMPTY, ONE, TWO});

endmodule

// File: tb/tb_result_mux_pipe.sv
// Bench for result_mux_pipe: directed tests on the default 3-source build and a
// randomized run on a 64-bit/5-source build, both against a 2-deep FIFO model.
module tb_result_mux_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: WIDTH=32, NUM_IN=3, SEL_W=2
    logic          flush_a, in_valid_a, in_ready_a, out_clamp_a, out_valid_a, out_ready_a;
    logic [95:0]   in_data_a;
    logic [1:0]    in_sel_a;
    logic [31:0]   out_data_a;

    // Instance B: WIDTH=64, NUM_IN=5, SEL_W=3
    logic          flush_b, in_valid_b, in_ready_b, out_clamp_b, out_valid_b, out_ready_b;
    logic [319:0]  in_data_b;
    logic [2:0]    in_sel_b;
    logic [63:0]   out_data_b;

    result_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush_a),
        .in_data(in_data_a), .in_sel(in_sel_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_clamp(out_clamp_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a)
    );

    result_mux_pipe #(.WIDTH(64), .NUM_IN(5), .SEL_W(3)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush_b),
        .in_data(in_data_b), .in_sel(in_sel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_clamp(out_clamp_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        c;
    } ent_t;

    // Model: each stage is a FIFO of capacity 2; the shown entry is the head,
    // or the last head once the FIFO empties.
    ent_t qa[$];
    ent_t qb[$];
    ent_t sha, shb;
    bit   started = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic ent_t pick(input logic [319:0] src, input int n, input int w, input int sel);
        ent_t        e;
        int          idx;
        logic [63:0] mask;
        idx  = (sel >= n) ? n - 1 : sel;
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        e.d  = 64'(src >> (idx * w)) & mask;
        e.c  = (sel >= n);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        bit acc, deq;
        @(posedge clk);
        if (reset) begin
            qa.delete(); qb.delete();
            sha = '0; shb = '0;
            started = 1'b1;
        end else begin
            if (flush_a) qa.delete();
            else begin
                deq = (qa.size() > 0) && out_ready_a;
                acc = in_valid_a && (qa.size() < 2);
                if (deq) void'(qa.pop_front());
                if (acc) qa.push_back(pick({224'd0, in_data_a}, 3, 32, int'(in_sel_a)));
                if (qa.size() > 0) sha = qa[0];
            end
            if (flush_b) qb.delete();
            else begin
                deq = (qb.size() > 0) && out_ready_b;
                acc = in_valid_b && (qb.size() < 2);
                if (deq) void'(qb.pop_front());
                if (acc) qb.push_back(pick(in_data_b, 5, 64, int'(in_sel_b)));
                if (qb.size() > 0) shb = qb[0];
            end
        end
        @(negedge clk);
        if (started) begin
            chk("a_out_valid", 64'(out_valid_a), 64'(qa.size() > 0));
            chk("a_in_ready",  64'(in_ready_a),  64'(qa.size() < 2));
            chk("a_out_data",  64'(out_data_a),  sha.d);
            chk("a_out_clamp", 64'(out_clamp_a), 64'(sha.c));
            chk("b_out_valid", 64'(out_valid_b), 64'(qb.size() > 0));
            chk("b_in_ready",  64'(in_ready_b),  64'(qb.size() < 2));
            chk("b_out_data",  out_data_b,       shb.d);
            chk("b_out_clamp", 64'(out_clamp_b), 64'(shb.c));
        end
    endtask

    initial begin
        reset = 1'b1;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; in_sel_a = '0;
        in_data_a = {32'h33333333, 32'h22222222, 32'h11111111};
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1; in_sel_b = '0;
        in_data_b = '0;

        // Reset values
        tick(); tick();
        chk("lit_rst_valid", 64'(out_valid_a), 64'd0);
        chk("lit_rst_data",  64'(out_data_a),  64'd0);
        chk("lit_rst_clamp", 64'(out_clamp_a), 64'd0);
        reset = 1'b0;
        tick();
        chk("lit_rst_ready", 64'(in_ready_a), 64'd1);

        // Basic select, back-to-back
        in_valid_a = 1'b1;
        in_sel_a = 2'd0; tick(); chk("lit_sel0", 64'(out_data_a), 64'h11111111);
        in_sel_a = 2'd1; tick(); chk("lit_sel1", 64'(out_data_a), 64'h22222222);
        in_sel_a = 2'd2; tick(); chk("lit_sel2", 64'(out_data_a), 64'h33333333);
        chk("lit_sel2_clamp", 64'(out_clamp_a), 64'd0);

        // Clamp of select 3 onto source 2
        in_data_a[95:64] = 32'hDEADBEEF;
        in_sel_a = 2'd3; tick();
        chk("lit_clamp_data", 64'(out_data_a), 64'hDEADBEEF);
        chk("lit_clamp_flag", 64'(out_clamp_a), 64'd1);
        in_valid_a = 1'b0; tick();

        // Back-pressure through the skid entry
        in_sel_a = 2'd0; in_valid_a = 1'b1; in_data_a[31:0] = 32'hA; tick();
        out_ready_a = 1'b0; in_data_a[31:0] = 32'hB; tick();
        chk("lit_skid_ready", 64'(in_ready_a), 64'd0);
        chk("lit_skid_hold", 64'(out_data_a), 64'hA);
        in_data_a[31:0] = 32'hC; tick();
        chk("lit_skid_stall", 64'(out_data_a), 64'hA);
        out_ready_a = 1'b1; tick();
        chk("lit_skid_b", 64'(out_data_a), 64'hB);
        tick();
        chk("lit_skid_c", 64'(out_data_a), 64'hC);
        in_valid_a = 1'b0; tick();
        chk("lit_skid_empty", 64'(out_valid_a), 64'd0);

        // Flush while two entries are held
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_data_a[31:0] = 32'h5; tick();
        in_data_a[31:0] = 32'h6; tick();
        in_data_a[31:0] = 32'h7; flush_a = 1'b1; tick();
        chk("lit_flush_valid", 64'(out_valid_a), 64'd0);
        chk("lit_flush_ready", 64'(in_ready_a),  64'd1);
        chk("lit_flush_hold",  64'(out_data_a),  64'h5);
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; tick();
        chk("lit_flush_drop", 64'(out_valid_a), 64'd0);

        // Reset while two entries are held
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_data_a[31:0] = 32'h8; tick();
        in_data_a[31:0] = 32'h9; tick();
        reset = 1'b1; tick();
        chk("lit_mrst_valid", 64'(out_valid_a), 64'd0);
        chk("lit_mrst_data",  64'(out_data_a),  64'd0);
        reset = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; tick();
        chk("lit_mrst_ready", 64'(in_ready_a),  64'd1);
        chk("lit_mrst_drop",  64'(out_valid_a), 64'd0);

        // Wide build: clamp of selects 5..7 onto source 4
        for (int i = 0; i < 5; i++) in_data_b[i*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
        in_valid_b = 1'b1;
        in_sel_b = 3'd6; tick();
        chk("lit_b_sel6", out_data_b, 64'hA5A5_0000_0000_0004);
        chk("lit_b_sel6_clamp", 64'(out_clamp_b), 64'd1);
        in_sel_b = 3'd2; tick();
        chk("lit_b_sel2", out_data_b, 64'hA5A5_0000_0000_0002);
        in_sel_b = 3'd4; tick();
        chk("lit_b_sel4_clamp", 64'(out_clamp_b), 64'd0);
        in_valid_b = 1'b0; tick();

        // Randomized traffic on the wide build
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid_b  = ($urandom_range(0, 9) < 6);
            out_ready_b = ($urandom_range(0, 9) < 7);
            flush_b     = ($urandom_range(0, 99) == 0);
            in_sel_b    = 3'($urandom_range(0, 7));
            for (int i = 0; i < 5; i++) in_data_b[i*64 +: 64] = {$urandom, $urandom};
            tick();
        end
        in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
        tick(); tick();
        chk("b_drained", 64'(out_valid_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
